uart_wb_cmd_engine: RTL and testbench

//  Byte-stream command parser and Wishbone master, downstream of the UART receiver.

---
 rtl/uart_wb_cmd_engine.sv | 202 ++++++++++++++++++++
 tb/tb_uart_wb_cmd_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_cmd_engine.sv
// uart_wb_cmd_engine
//   Parses host command frames arriving byte-by-byte from a UART receiver and
//   runs the matching 32-bit Wishbone bursts.
//     write frame: 0x01, N, A3..A0, then N x (D3..D0)
//     read  frame: 0x02, N, A3..A0; each word read is returned MSB-first
//   N = 0 means 256 words. Addresses step by 4 and wrap modulo 2^32.
//   A bus cycle with no ack within WB_TIMEOUT cycles is abandoned: err pulses,
//   read data becomes 32'hFFFF_FFFF, and the frame carries on. Rx silence of
//   IDLE_TIMEOUT cycles in the middle of a frame drops the frame and pulses err.
// Ports
//   core_clk, core_rstn        clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready  inbound byte stream (taken on valid & ready)
//   tx_data/tx_valid/tx_ready  outbound response bytes
//   wbm_*                      Wishbone classic master
//   busy                       high whenever the parser is not idle
//   err                        one-cycle pulse on bus timeout or idle timeout
module uart_wb_cmd_engine #(
  parameter int unsigned WB_TIMEOUT   = 1024,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        err
);

  localparam int unsigned WbW = $clog2(WB_TIMEOUT);
  localparam int unsigned IdW = $clog2(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StLen, StAdr, StWdat, StWbw, StWbr, StRdat
  } state_e;

  state_e          state_q;
  logic            is_wr_q;
  logic [7:0]      cnt_q;
  logic [31:0]     adr_q;
  logic [31:0]     dat_q;
  logic [31:0]     rdat_q;
  logic [1:0]      bidx_q;
  logic            cyc_q;
  logic            txv_q;
  logic            err_q;
  logic [WbW-1:0]  wb_tmr_q;
  logic [IdW-1:0]  idle_tmr_q;

  logic in_frame;
  logic rx_hs;
  logic tx_hs;
  logic wb_to;
  logic wb_done;
  logic idle_to;

  assign in_frame = (state_q == StLen) || (state_q == StAdr) || (state_q == StWdat);
  assign rx_ready = in_frame || (state_q == StIdle);
  assign rx_hs    = rx_valid && rx_ready;
  assign tx_hs    = txv_q && tx_ready;
  // Timeout fires on the WB_TIMEOUT-th cycle of cyc without an ack.
  assign wb_to    = cyc_q && !wbm_ack_i && (wb_tmr_q == WbW'(WB_TIMEOUT - 1));
  assign wb_done  = cyc_q && (wbm_ack_i || wb_to);
  assign idle_to  = in_frame && !rx_hs && (idle_tmr_q == IdW'(IDLE_TIMEOUT - 1));

  assign tx_data   = rdat_q[31:24];
  assign tx_valid  = txv_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q && is_wr_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rdat_q     <= '0;
      bidx_q     <= '0;
      cyc_q      <= 1'b0;
      txv_q      <= 1'b0;
      err_q      <= 1'b0;
      wb_tmr_q   <= '0;
      idle_tmr_q <= '0;
    end else begin
      err_q <= 1'b0;

      if (cyc_q) wb_tmr_q <= wb_tmr_q + WbW'(1);
      else       wb_tmr_q <= '0;

      if (!in_frame || rx_hs) idle_tmr_q <= '0;
      else                    idle_tmr_q <= idle_tmr_q + IdW'(1);

      unique case (state_q)
        StIdle: begin
          if (rx_hs && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            is_wr_q <= (rx_data == 8'h01);
            state_q <= StLen;
          end
        end
        StLen: begin
          if (idle_to) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (rx_hs) begin
            cnt_q   <= rx_data;
            bidx_q  <= '0;
            state_q <= StAdr;
          end
        end
        StAdr: begin
          if (idle_to) begin
            err_q   <= 1'b1;
            bidx_q  <= '0;
            state_q <= StIdle;
          end else if (rx_hs) begin
            adr_q  <= {adr_q[23:0], rx_data};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= StWdat;
              end else begin
                cyc_q   <= 1'b1;
                state_q <= StWbr;
              end
            end
          end
        end
        StWdat: begin
          if (idle_to) begin
            err_q   <= 1'b1;
            bidx_q  <= '0;
            state_q <= StIdle;
          end else if (rx_hs) begin
            dat_q  <= {dat_q[23:0], rx_data};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              cyc_q   <= 1'b1;
              state_q <= StWbw;
            end
          end
        end
        StWbw: begin
          if (wb_done) begin
            cyc_q   <= 1'b0;
            err_q   <= wb_to;
            adr_q   <= adr_q + 32'd4;
            cnt_q   <= cnt_q - 8'd1;
            // cnt_q == 1 means this was the last word; N = 0 runs 256 words.
            state_q <= (cnt_q != 8'd1) ? StWdat : StIdle;
          end
        end
        StWbr: begin
          if (wb_done) begin
            cyc_q   <= 1'b0;
            err_q   <= wb_to;
            rdat_q  <= wb_to ? 32'hFFFF_FFFF : wbm_dat_i;
            txv_q   <= 1'b1;
            bidx_q  <= '0;
            state_q <= StRdat;
          end
        end
        StRdat: begin
          if (tx_hs) begin
            rdat_q <= {rdat_q[23:0], 8'h00};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              txv_q <= 1'b0;
              adr_q <= adr_q + 32'd4;
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q != 8'd1) begin
                cyc_q   <= 1'b1;
                state_q <= StWbr;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_cmd_engine.sv
// Self-checking bench for uart_wb_cmd_engine: directed frames plus randomized
// write/read-back bursts, checked against a word-level model of the protocol.
module tb_uart_wb_cmd_engine;

  localparam int WBT = 20;
  localparam int IDT = 300;

  logic        clk;
  logic        core_rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;
  logic        err;

  uart_wb_cmd_engine #(
    .WB_TIMEOUT   (WBT),
    .IDLE_TIMEOUT (IDT)
  ) dut (
    .core_clk  (clk),
    .core_rstn (core_rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_rec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed traffic
  wb_rec_t      wb_log[$];
  logic [7:0]   got_tx[$];
  logic [31:0]  mem[logic [31:0]];
  int           cyc_cycles = 0;
  int           err_cnt    = 0;
  int           acks       = 0;
  int           proto_bad  = 0;
  logic         tx_hold    = 1'b0;
  logic [7:0]   tx_hold_d  = 8'h00;

  // Reference model state
  wb_rec_t      exp_log[$];
  logic [7:0]   exp_tx[$];
  logic [31:0]  ref_mem[logic [31:0]];

  logic slave_en    = 1'b1;
  logic tx_rdy_mode = 1'b1;
  int   wait_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Wishbone slave: acks 0..2 cycles after cyc is seen.
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    if (!wbm_cyc_o) begin
      wait_cnt = $urandom_range(0, 2);
    end else if (slave_en) begin
      if (wait_cnt == 0) begin
        wbm_ack_i = 1'b1;
        if (wbm_we_o) begin
          mem[wbm_adr_o] = wbm_dat_o;
          wb_log.push_back(wb_rec_t'({1'b1, wbm_adr_o, wbm_dat_o}));
        end else begin
          wbm_dat_i = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'hDEAD_BEEF;
          wb_log.push_back(wb_rec_t'({1'b0, wbm_adr_o, 32'h0}));
        end
        wait_cnt = $urandom_range(0, 2);
      end else begin
        wait_cnt--;
      end
    end
  end

  always @(negedge clk) tx_ready = tx_rdy_mode && ($urandom_range(0, 3) != 0);

  // Monitor: bus/tx protocol rules and event counters.
  always @(posedge clk) begin
    if (core_rstn) begin
      if (wbm_cyc_o) cyc_cycles++;
      if (err) err_cnt++;
      if (wbm_ack_i && wbm_cyc_o) acks++;
      if (wbm_stb_o !== wbm_cyc_o) proto_bad++;
      if (wbm_sel_o !== (wbm_cyc_o ? 4'hF : 4'h0)) proto_bad++;
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (tx_hold && (!tx_valid || tx_data !== tx_hold_d)) proto_bad++;
      tx_hold   = tx_valid && !tx_ready;
      tx_hold_d = tx_data;
    end else begin
      tx_hold = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check("rx accept timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic hdr(input logic [7:0] cmd, input int n, input logic [31:0] adr,
                     output logic [7:0] b[$]);
    b = {};
    b.push_back(cmd);
    b.push_back(8'(n));
    b.push_back(adr[31:24]);
    b.push_back(adr[23:16]);
    b.push_back(adr[15:8]);
    b.push_back(adr[7:0]);
  endtask

  // Model: a write of n words lands at adr, adr+4, ... (mod 2^32).
  task automatic do_write(input logic [31:0] adr, input int n, input logic [31:0] w[$]);
    logic [7:0]  b[$];
    logic [31:0] a;
    int          words;
    words = (n == 0) ? 256 : n;
    hdr(8'h01, n, adr, b);
    for (int i = 0; i < words; i++) begin
      a = adr + 32'(4 * i);
      b.push_back(w[i][31:24]);
      b.push_back(w[i][23:16]);
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
      exp_log.push_back(wb_rec_t'({1'b1, a, w[i]}));
      ref_mem[a] = w[i];
    end
    send_bytes(b);
  endtask

  // Model: a read returns each word MSB-first; a dead bus yields all-ones.
  task automatic do_read(input logic [31:0] adr, input int n);
    logic [7:0]  b[$];
    logic [31:0] a;
    logic [31:0] word;
    int          words;
    words = (n == 0) ? 256 : n;
    hdr(8'h02, n, adr, b);
    for (int i = 0; i < words; i++) begin
      a = adr + 32'(4 * i);
      if (!slave_en) word = 32'hFFFF_FFFF;
      else if (ref_mem.exists(a)) word = ref_mem[a];
      else word = 32'hDEAD_BEEF;
      for (int k = 3; k >= 0; k--) exp_tx.push_back(8'(word >> (8 * k)));
      if (slave_en) exp_log.push_back(wb_rec_t'({1'b0, a, 32'h0}));
    end
    send_bytes(b);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    wait_idle(tag);
    check({tag, " nwb"}, 32'(wb_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < wb_log.size(); i++) begin
      check($sformatf("%s we%0d", tag, i), 32'(wb_log[i].we), 32'(exp_log[i].we));
      check($sformatf("%s adr%0d", tag, i), wb_log[i].adr, exp_log[i].adr);
      check($sformatf("%s dat%0d", tag, i), wb_log[i].dat, exp_log[i].dat);
    end
    check({tag, " ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      check($sformatf("%s tx%0d", tag, i), 32'(got_tx[i]), 32'(exp_tx[i]));
    wb_log = {};
    exp_log = {};
    got_tx = {};
    exp_tx = {};
  endtask

  task automatic rand_words(input int n, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back($urandom);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] a;
    logic [7:0]  b[$];
    int          n;
    int          e0;
    int          k0;
    int          t;

    core_rstn = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    wbm_dat_i = 32'h0;
    wbm_ack_i = 1'b0;
    tx_ready  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst rx_ready", 32'(rx_ready), 32'd1);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst stb", 32'(wbm_stb_o), 32'd0);
    check("rst we", 32'(wbm_we_o), 32'd0);
    check("rst sel", 32'(wbm_sel_o), 32'd0);
    check("rst adr", wbm_adr_o, 32'd0);
    check("rst dat", wbm_dat_o, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst err", 32'(err), 32'd0);
    core_rstn = 1'b1;
    @(negedge clk);

    // T1: single write
    w = {32'h7755_55AB};
    do_write(32'h0100_0094, 1, w);
    check_frame("T1");

    // T2: single read, fixed slave data
    mem[32'h0100_0094]     = 32'h1234_5678;
    ref_mem[32'h0100_0094] = 32'h1234_5678;
    do_read(32'h0100_0094, 1);
    check_frame("T2");

    // T3: write burst wrapping past 2^32
    k0 = acks;
    rand_words(3, w);
    do_write(32'hFFFF_FFF8, 3, w);
    check_frame("T3");
    check("T3 acks", 32'(acks - k0), 32'd3);

    // T4: dead slave -> timeout, all-ones data, one err pulse
    slave_en   = 1'b0;
    cyc_cycles = 0;
    e0         = err_cnt;
    do_read(32'h0000_1000, 1);
    check_frame("T4");
    check("T4 cyc cycles", 32'(cyc_cycles), 32'(WBT));
    check("T4 err pulses", 32'(err_cnt - e0), 32'd1);
    slave_en = 1'b1;

    // T5: garbage dropped, then stalled partial frame times out
    send_byte(8'h55);
    check("T5 garbage busy", 32'(busy), 32'd0);
    e0 = err_cnt;
    b  = {8'h01, 8'h01, 8'h01};
    send_bytes(b);
    check("T5 partial busy", 32'(busy), 32'd1);
    repeat (IDT - 3) @(negedge clk);
    check("T5 before timeout busy", 32'(busy), 32'd1);
    check("T5 before timeout err", 32'(err_cnt - e0), 32'd0);
    repeat (10) @(negedge clk);
    check("T5 after timeout busy", 32'(busy), 32'd0);
    check("T5 timeout err", 32'(err_cnt - e0), 32'd1);
    check("T5 no wb", 32'(wb_log.size()), 32'd0);
    rand_words(2, w);
    do_write(32'h0000_2000, 2, w);
    check_frame("T5 write");
    do_read(32'h0000_2000, 2);
    check_frame("T5 read");

    // Randomized write / read-back bursts
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 4);
      a = $urandom & 32'hFFFF_FFFC;
      rand_words(n, w);
      do_write(a, n, w);
      check_frame($sformatf("R%0d wr", it));
      do_read(a, n);
      check_frame($sformatf("R%0d rd", it));
    end

    // N=0 encodes 256 words
    do_read($urandom & 32'hFFFF_FFFC, 0);
    check_frame("N0 rd");

    // T6: reset while waiting in WBR with tx stalled
    tx_rdy_mode = 1'b0;
    slave_en    = 1'b0;
    hdr(8'h02, 1, 32'h0000_3000, b);
    send_bytes(b);
    repeat (3) @(negedge clk);
    check("T6 cyc before rst", 32'(wbm_cyc_o), 32'd1);
    core_rstn = 1'b0;
    @(negedge clk);
    check("T6 cyc", 32'(wbm_cyc_o), 32'd0);
    check("T6 stb", 32'(wbm_stb_o), 32'd0);
    check("T6 tx_valid", 32'(tx_valid), 32'd0);
    check("T6 rx_ready", 32'(rx_ready), 32'd1);
    check("T6 busy", 32'(busy), 32'd0);
    core_rstn = 1'b1;
    @(negedge clk);

    // Reset while a response byte is held un-accepted
    slave_en = 1'b1;
    send_bytes(b);
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("T6b tx_valid before rst", 32'(tx_valid), 32'd1);
    core_rstn = 1'b0;
    @(negedge clk);
    check("T6b tx_valid", 32'(tx_valid), 32'd0);
    check("T6b cyc", 32'(wbm_cyc_o), 32'd0);
    check("T6b busy", 32'(busy), 32'd0);
    core_rstn   = 1'b1;
    wb_log      = {};
    got_tx      = {};
    tx_rdy_mode = 1'b1;
    @(negedge clk);

    // Normal operation after reset
    rand_words(2, w);
    do_write(32'h0000_4000, 2, w);
    check_frame("post rst wr");
    do_read(32'h0000_4000, 2);
    check_frame("post rst rd");

    check("protocol violations", 32'(proto_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
